// File: rtl/sramlike_bus_arbiter_pkg.sv
// Shared encodings for the two-master sram-like bus arbiter: FSM states,
// transaction owner identifiers and sram-like transfer size codes.
package sramlike_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/sramlike_bus_arbiter.sv
// Shares one sram-like slave port between instruction and data masters, one
// outstanding transaction. Define ARB_ROUND_ROBIN_EN for alternating grants.
module sramlike_bus_arbiter
    import sramlike_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic              i_wr,
    input  logic [1:0]        i_size,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,

    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_t state, state_nxt;
    logic       owner, owner_nxt;
    logic       grant;
    logic       sel;
    logic       sel_req;
    logic       req_int;
    logic       addr_ok_int;
    logic       data_ok_int;

`ifdef ARB_ROUND_ROBIN_EN
    logic       last_grant;
`endif

    // Grant is only meaningful in IDLE; afterwards the latched owner steers the mux.
    always_comb begin
        grant = d_req ? OWN_DATA : OWN_INST;
`ifdef ARB_ROUND_ROBIN_EN
        if (d_req && i_req) begin
            grant = (last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
        end
`endif
    end

    assign sel     = (state == ARB_IDLE) ? grant : owner;
    assign sel_req = (sel == OWN_DATA) ? d_req : i_req;

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        req_int     = 1'b0;
        addr_ok_int = 1'b0;
        data_ok_int = 1'b0;
        case (state)
            ARB_IDLE: begin
                req_int = sel_req;
                if (sel_req) begin
                    owner_nxt   = grant;
                    addr_ok_int = m_addr_ok;
                    state_nxt   = m_addr_ok ? ARB_DATA : ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                req_int = sel_req;
                // A dropped request is a pipeline flush: abandon without issuing.
                if (!sel_req) begin
                    state_nxt = ARB_IDLE;
                end else if (m_addr_ok) begin
                    addr_ok_int = 1'b1;
                    state_nxt   = ARB_DATA;
                end
            end
            ARB_DATA: begin
                data_ok_int = m_data_ok;
                if (m_data_ok) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            owner <= OWN_INST;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWN_INST;
        end else if ((state != ARB_DATA) && (state_nxt == ARB_DATA)) begin
            last_grant <= owner_nxt;
        end
    end
`endif

    assign m_req   = req_int & ~rst;
    assign m_wr    = (sel == OWN_DATA) ? d_wr    : i_wr;
    assign m_size  = (sel == OWN_DATA) ? d_size  : i_size;
    assign m_addr  = (sel == OWN_DATA) ? d_addr  : i_addr;
    assign m_wdata = (sel == OWN_DATA) ? d_wdata : i_wdata;

    assign i_addr_ok = addr_ok_int & (sel == OWN_INST) & ~rst;
    assign d_addr_ok = addr_ok_int & (sel == OWN_DATA) & ~rst;
    assign i_data_ok = data_ok_int & (owner == OWN_INST) & ~rst;
    assign d_data_ok = data_ok_int & (owner == OWN_DATA) & ~rst;

    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule

// File: doc/sramlike_bus_arbiter.md
Name: sramlike_bus_arbiter

Overview:
- Shares a single sram-like slave port (toward the AXI bridge) between two sram-like masters: instruction side (i_*) and data side (d_*).
- Each master is the output of its sram2sramlike converter; the slave side connects to the bridge.
- Supports one outstanding transaction; data side has priority by default.
- Routes addr_ok/data_ok back only to the master that owns the transaction.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, read/write data width

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- i_req  in  1  inst master request
- i_wr  in  1  inst write flag (normally 0)
- i_size  in  2  inst size (00 byte, 01 half, 10 word)
- i_addr  in  ADDR_W  inst address
- i_wdata  in  DATA_W  inst write data
- i_addr_ok  out  1  inst address handshake
- i_data_ok  out  1  inst data handshake
- i_rdata  out  DATA_W  inst read data
- d_req, d_wr, d_size, d_addr, d_wdata  in  1/1/2/ADDR_W/DATA_W  data master, same meaning as i_*
- d_addr_ok, d_data_ok, d_rdata  out  1/1/DATA_W  data master responses
- m_req, m_wr, m_size, m_addr, m_wdata  out  1/1/2/ADDR_W/DATA_W  to slave
- m_addr_ok, m_data_ok, m_rdata  in  1/1/DATA_W  from slave

Behaviour:
- States:
  - IDLE: no transaction.
  - ADDR: owner locked, waiting for m_addr_ok.
  - DATA: address accepted, waiting for m_data_ok.
- Registers: state, owner (0 = inst, 1 = data).
- Reset: state=IDLE, owner=0. While rst is high, all *_addr_ok, *_data_ok and m_req are 0.
- IDLE:
  - Combinational grant: d_req wins; else i_req.
  - m_req = granted req; m_* fields muxed from the granted master.
  - Granted master's addr_ok = m_addr_ok, in the same cycle (zero-latency pass-through).
  - m_addr_ok=1 → DATA, owner latched.
  - Request but no m_addr_ok → ADDR, owner latched.
  - No request → stay IDLE.
- ADDR:
  - m_* fields come from the owner regardless of the other master's req.
  - m_req = owner's req.
  - Owner drops req (pipeline flush): return to IDLE next cycle, no transaction issued.
  - m_addr_ok → DATA.
- DATA:
  - m_req=0; both *_addr_ok=0.
  - owner_data_ok = m_data_ok; on m_data_ok → IDLE.
  - The next grant happens in IDLE, so there is a fixed 1-cycle bubble between transactions.
- Read data: m_rdata is driven to both i_rdata and d_rdata unconditionally. Only the owner's data_ok qualifies it.
- Stray m_data_ok in IDLE or ADDR: ignored, not forwarded to either master.
- Non-owner master: addr_ok=0 and data_ok=0 at all times; its req is held pending with no side effect.
- m_addr_ok and m_data_ok in the same cycle cannot be legal (single outstanding). If it occurs in ADDR, only addr_ok is honoured.
- Reset mid-transaction: state returns to IDLE. An in-flight slave response arriving after reset is discarded as stray.
- Latency: best case addr_ok in the request cycle; data_ok passes through with zero added latency.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - 1-bit last_grant register, reset 0 (inst).
  - In IDLE with both requests pending, the grant goes to the master not served last.
  - last_grant updates when a transaction enters DATA.
- Not defined: fixed data-side priority. Instruction starvation is acceptable because data requests are bounded by pipeline stalls.

Decomposition:
- Shared package holds:
  - state encoding (ARB_IDLE=2'd0, ARB_ADDR=2'd1, ARB_DATA=2'd2);
  - owner constants (OWN_INST=1'b0, OWN_DATA=1'b1);
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
- Single module; no sub-module is warranted. The priority/round-robin select stays inline as one combinational block.

Test Plan:
- Inst only: i_req=1, addr 0xBFC00000; slave addr_ok in cycle 0, data_ok cycle 3 with rdata 0x3C080001 → i_addr_ok in cycle 0, i_data_ok in cycle 3, i_rdata=0x3C080001, d_* ok outputs stay 0.
- Simultaneous requests: i_req=d_req=1, d_wr=1, d_addr=0x80000010, d_wdata=0xDEADBEEF → m_addr=0x80000010, m_wr=1. Inst is granted after d_data_ok plus 1 bubble cycle.
- Lock in ADDR: d_req held, slave withholds addr_ok 4 cycles, i_req asserted meanwhile → m_addr stays the d address, i_addr_ok=0 throughout.
- Stray response: m_data_ok=1 in IDLE → i_data_ok=d_data_ok=0, state stays IDLE.
- Reset mid-DATA: rst=1 for one cycle, then stale m_data_ok → no *_data_ok pulse; next i_req is served normally.
- ARB_ROUND_ROBIN_EN: both masters request continuously for 4 transactions → grant order D, I, D, I. Without the macro → D, D, D, D.
